// File: rtl/mem_req_dispatch_pkg.sv
// Shared types and constants for the memory command front end.
// The address map is {row, bank, bank_group, col}, with col in the least significant bits.
package mem_pkg;
  localparam int QUEUE_SIZE = 16;
  localparam int BG_W       = 3;
  localparam int BANK_W     = 3;
  localparam int ROW_W      = 8;
  localparam int COL_W      = 8;
  localparam int ADDR_W     = ROW_W + BANK_W + BG_W + COL_W;
  localparam int IDX_W      = BG_W + BANK_W;
  localparam int CRED_W     = $clog2(QUEUE_SIZE) + 1;

  localparam logic [2:0] ST_NEED_PRE = 3'b000;
  localparam logic [2:0] ST_PRE_PEND = 3'b001;
  localparam logic [2:0] ST_ACT_RDY  = 3'b010;
  localparam logic [2:0] ST_ACT_PEND = 3'b011;
  localparam logic [2:0] ST_RW_RDY   = 3'b100;
  localparam logic [2:0] ST_RW_PEND  = 3'b101;
  localparam logic [2:0] ST_RW_DONE  = 3'b110;

  typedef struct packed {
    logic [BG_W-1:0]   bank_group;
    logic [BANK_W-1:0] bank;
    logic [ROW_W-1:0]  row;
    logic [COL_W-1:0]  col;
    logic [63:0]       val_in;
    logic [2:0]        state;
    logic [31:0]       cycle_count;
    logic              write;
    logic              valid;
  } mem_request_t;

  function automatic mem_request_t decode_addr(input logic [ADDR_W-1:0] addr);
    mem_request_t r;
    r            = '0;
    r.col        = addr[COL_W-1:0];
    r.bank_group = addr[COL_W +: BG_W];
    r.bank       = addr[COL_W+BG_W +: BANK_W];
    r.row        = addr[COL_W+BG_W+BANK_W +: ROW_W];
    return r;
  endfunction
endpackage

// File: rtl/mem_req_dispatch_if.sv
// Request and queue-side signals of the dispatch stage.
// The slave modport is the dispatch view; the master modport is the view of the agent driving it.
interface mem_req_dispatch_if;
  import mem_pkg::*;

  logic                req_valid_in;
  logic                req_ready_out;
  logic [ADDR_W-1:0]   req_addr_in;
  logic                req_write_in;
  logic [63:0]         req_data_in;
  logic                precharge_all_in;
  logic                dequeue_in;
  logic                enqueue_out;
  mem_request_t        req_out;
  logic [31:0]         cycle_count_out;
  logic [CRED_W-1:0]   credits_out;

  modport slave (
    input  req_valid_in, req_addr_in, req_write_in, req_data_in,
           precharge_all_in, dequeue_in,
    output req_ready_out, enqueue_out, req_out, cycle_count_out, credits_out
  );

  modport master (
    output req_valid_in, req_addr_in, req_write_in, req_data_in,
           precharge_all_in, dequeue_in,
    input  req_ready_out, enqueue_out, req_out, cycle_count_out, credits_out
  );
endinterface

// File: rtl/mem_req_dispatch_open_row_table.sv
// Open-row table with one entry per bank: a write is registered on the clock edge and a read is combinational.
// Open bits clear asynchronously on reset and synchronously on precharge-all; row values need no reset.
module open_row_table
  import mem_pkg::*;
(
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             clear_in,
  input  logic             wr_en_in,
  input  logic [IDX_W-1:0] wr_idx_in,
  input  logic [ROW_W-1:0] wr_row_in,
  input  logic [IDX_W-1:0] rd_idx_in,
  output logic             rd_open_out,
  output logic [ROW_W-1:0] rd_row_out
);
  localparam int ENTRIES = 1 << IDX_W;

  logic [ENTRIES-1:0] open_q;
  logic [ROW_W-1:0]   row_q [ENTRIES];

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in)     open_q <= '0;
    else if (clear_in) open_q <= '0;
    else if (wr_en_in) open_q[wr_idx_in] <= 1'b1;
  end

  always_ff @(posedge clk_in) begin
    if (wr_en_in) row_q[wr_idx_in] <= wr_row_in;
  end

  assign rd_open_out = open_q[rd_idx_in];
  assign rd_row_out  = row_q[rd_idx_in];
endmodule

// File: rtl/mem_req_dispatch.sv
// Dispatch front end: accepts requests, classifies them against the open-row table, and stamps them.
// It pushes each request into the ready queue one cycle after accept and tracks the free slots in that queue.
module mem_req_dispatch
  import mem_pkg::*;
(
  input  logic               clk_in,
  input  logic               rst_n_in,
  mem_req_dispatch_if.slave  bus
);
  logic [31:0]       cycle_q;
  logic [CRED_W-1:0] credits_q, credits_d;
  logic              enq_q;
  mem_request_t      req_q, new_req;
  logic              accept, deq_ok;
  logic              tbl_open;
  logic [ROW_W-1:0]  tbl_row;
  logic [IDX_W-1:0]  idx;

  // Ready never looks at dequeue, so a credit returned at zero only shows up next cycle.
  assign bus.req_ready_out = rst_n_in && (credits_q != '0) && !bus.precharge_all_in;
  assign accept = bus.req_valid_in && bus.req_ready_out;
  assign deq_ok = bus.dequeue_in && (credits_q != CRED_W'(QUEUE_SIZE));

  always_comb begin
    new_req             = decode_addr(bus.req_addr_in);
    new_req.val_in      = bus.req_data_in;
    new_req.write       = bus.req_write_in;
    new_req.valid       = 1'b1;
    new_req.cycle_count = cycle_q;
    if (!tbl_open)                  new_req.state = ST_ACT_RDY;
    else if (tbl_row == new_req.row) new_req.state = ST_RW_RDY;
    else                            new_req.state = ST_NEED_PRE;
  end

  assign idx = {new_req.bank_group, new_req.bank};

  open_row_table u_open_row_table (
    .clk_in      (clk_in),
    .rst_n_in    (rst_n_in),
    .clear_in    (bus.precharge_all_in),
    .wr_en_in    (accept),
    .wr_idx_in   (idx),
    .wr_row_in   (new_req.row),
    .rd_idx_in   (idx),
    .rd_open_out (tbl_open),
    .rd_row_out  (tbl_row)
  );

  always_comb begin
    credits_d = credits_q;
    if (accept && !deq_ok)      credits_d = credits_q - CRED_W'(1);
    else if (!accept && deq_ok) credits_d = credits_q + CRED_W'(1);
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      cycle_q   <= '0;
      credits_q <= CRED_W'(QUEUE_SIZE);
      enq_q     <= 1'b0;
      req_q     <= '0;
    end else begin
      assert (!(bus.dequeue_in && credits_q == CRED_W'(QUEUE_SIZE)));
      cycle_q   <= cycle_q + 32'd1;
      credits_q <= credits_d;
      enq_q     <= accept;
      if (accept) req_q <= new_req;
    end
  end

  assign bus.enqueue_out     = enq_q;
  assign bus.req_out         = req_q;
  assign bus.cycle_count_out = cycle_q;
  assign bus.credits_out     = credits_q;
endmodule
